// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Iterative shift-add multiplier for the RV32M multiply group (MUL, MULH,
// MULHSU, MULHU). Operands are converted to magnitudes on accept. The
// unsigned 2*XLEN-bit product is built over XLEN CALC cycles. One SIGN cycle
// then applies the sign and selects the requested half. Latency is fixed:
// done is high in the cycle after the (XLEN+1)-th edge following the accept
// edge.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, accepted only in IDLE when flush is low
//   flush   synchronous abort: return to IDLE, no done, result untouched
//   op      00 MUL (low half), 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u)
//   a       multiplicand (rs1), sampled on the accept edge
//   b       multiplier (rs2), sampled on the accept edge
//   busy    high while in CALC or SIGN (registered)
//   done    one-cycle pulse when result is valid (registered)
//   result  selected product half, held until the next done
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int PW = 2 * XLEN;
  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]      op_reg;
  logic            neg_reg;      // product must be negated in SIGN
  logic [PW-1:0]   mcand_reg;    // multiplicand, shifted left once per iteration
  logic [XLEN-1:0] mplier_reg;   // multiplier, shifted right once per iteration
  logic [PW-1:0]   acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [XLEN-1:0] result_reg;

  logic            accept;
  logic            sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [PW-1:0]   prod;

  assign accept = (state_reg == IDLE) && start && !flush;

  // Only the operands interpreted as signed contribute a sign flag.
  // MUL uses unsigned magnitudes because its low half does not depend on
  // signedness.
  assign sa = a[XLEN-1] && ((op == 2'b01) || (op == 2'b10));
  assign sb = b[XLEN-1] && (op == 2'b01);

  // The most negative value negates to itself. As an unsigned magnitude it
  // is 2^(XLEN-1), which is the correct value, so no overflow handling is
  // needed.
  assign a_mag = sa ? (~a + XLEN'(1)) : a;
  assign b_mag = sb ? (~b + XLEN'(1)) : b;

  assign prod = neg_reg ? (~acc_reg + PW'(1)) : acc_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_reg == LAST_ITER) begin
          state_next = SIGN;
        end
      end
      SIGN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= 2'b00;
      neg_reg    <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg     <= op;
            neg_reg    <= sa ^ sb;
            mcand_reg  <= {{XLEN{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        CALC: begin
          if (mplier_reg[0]) begin
            acc_reg <= acc_reg + mcand_reg;
          end
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + CW'(1);
        end
        SIGN: begin
          // A flush in the SIGN cycle discards the result.
          if (!flush) begin
            result_reg <= (op_reg == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
            done_reg   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Directed scenarios followed by randomized operations. Expected results
// come from plain 64-bit arithmetic on sign- or zero-extended operands.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_mis = 0;

  seq_multiplier #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the full product of the extended operands, truncated to 64 bits.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    logic [63:0] xe, ye, p;
    xe = {32'b0, x};
    ye = {32'b0, y};
    if (o == 2'b01 || o == 2'b10) xe = {{32{x[31]}}, x};
    if (o == 2'b01)               ye = {{32{y[31]}}, y};
    p = xe * ye;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issues one operation from IDLE and waits for done.
  // lat is the number of clock edges after the accept edge until done is seen.
  // bcnt is the number of sampled cycles with busy high.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    // Scramble the inputs to confirm that the operands were latched.
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    lat   = 0;
    bcnt  = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    r = result;
    $display("op=%0d a=%08h b=%08h result=%08h latency=%0d", o, x, y, r, lat);
  endtask

  logic [31:0] r;
  int          lat, bcnt, k, dcnt;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    rst_n = 1'b1;

    // MUL 7 * -3
    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, r, lat, bcnt);
    check("mul_neg_result", 64'(r), 64'hFFFF_FFEB);
    check("mul_neg_latency", 64'(lat), 64'd33);
    check("mul_neg_busy_cycles", 64'(bcnt), 64'd33);
    check("mul_neg_busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("done_single_pulse", 64'(done), 64'd0);

    // High-half boundary cases
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, r, lat, bcnt);
    check("mulh_minmin", 64'(r), 64'h4000_0000);
    do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bcnt);
    check("mulhu_maxmax", 64'(r), 64'hFFFF_FFFE);
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bcnt);
    check("mulhsu_m1max", 64'(r), 64'hFFFF_FFFF);
    check("mulhsu_latency", 64'(lat), 64'd33);

    // Back-to-back with start held high throughout
    @(negedge clk);
    start = 1'b1;
    op    = 2'b11;
    a     = 32'h0001_0000;
    b     = 32'h0001_0000;
    @(negedge clk);
    op = 2'b00;
    a  = 32'd3;
    b  = 32'd5;
    k  = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_first_latency", 64'(k), 64'd33);
    check("b2b_first_result", 64'(result), 64'h0000_0001);
    $display("op=3 a=00010000 b=00010000 result=%08h latency=%0d", result, k);
    // The second accept happens on the edge that ends this done cycle.
    k = 0;
    @(negedge clk);
    k++;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("b2b_second_gap", 64'(k), 64'd34);
    check("b2b_second_result", 64'(result), 64'h0000_000F);
    $display("op=0 a=00000003 b=00000005 result=%08h latency=%0d", result, k - 1);

    // Flush at CALC iteration 10
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_drop", 64'(busy), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(dcnt), 64'd0);
    check("flush_result_kept", 64'(result), 64'h0000_000F);
    $display("flush: busy=%0b result=%08h done_pulses=%0d", busy, result, dcnt);
    do_op(2'b11, 32'hFFFF_FFFF, 32'd2, r, lat, bcnt);
    check("after_flush_result", 64'(r), 64'h0000_0001);
    check("after_flush_latency", 64'(lat), 64'd33);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'h1234;
    b     = 32'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    $display("async reset: busy=%0b done=%0b result=%08h", busy, done, result);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b00, 32'd0, 32'h1234_5678, r, lat, bcnt);
    check("post_rst_zero", 64'(r), 64'd0);
    check("post_rst_latency", 64'(lat), 64'd33);

    // Randomized operations
    for (int i = 0; i < 1000; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      do_op(ro, ra, rb, r, lat, bcnt);
      check($sformatf("rand%0d_result", i), 64'(r), 64'(ref_model(ro, ra, rb)));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Multi-cycle iterative shift-add multiplier that complements the combinational divider in the ALU datapath, covering the RV32M multiply group (MUL, MULH, MULHSU, MULHU).
- Takes two 32-bit operands on a start pulse.
- Computes the full 64-bit product over 32 iteration cycles.
- Returns the selected 32-bit half with a one-cycle done pulse.
- The core stalls on busy.

Parameters:
XLEN, 32, operand/result width; product is 2*XLEN; iteration count equals XLEN.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only in IDLE
flush  input  1  synchronous abort; returns to IDLE, no done
op  input  2  00 MUL (low, any sign), 01 MULH (s*s high), 10 MULHSU (s*u high), 11 MULHU (u*u high)
a  input  XLEN  multiplicand (rs1), sampled on accept
b  input  XLEN  multiplier (rs2), sampled on accept
busy  output  1  high in CALC and SIGN
done  output  1  one-cycle pulse when result valid
result  output  XLEN  selected product half; held until next done

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; busy=0, done=0, result=0.
  - Internal accumulator, operand registers and counter cleared.
- States:
  - IDLE -> CALC on start && !flush.
  - CALC -> SIGN after XLEN iterations.
  - SIGN -> IDLE.
- Accept edge (IDLE, start=1):
  - Latch op.
  - Latch sign flags: sa = a[XLEN-1] for op 01/10; sb = b[XLEN-1] for op 01 only.
  - Latch magnitudes |a|, |b| (two's-complement negate when the flag is set).
  - Clear accumulator[2*XLEN-1:0] and counter.
- CALC, each edge:
  - If multiplier LSB=1, add multiplicand, zero-extended and shifted by counter, to accumulator (or equivalent shift-right accumulator form).
  - Shift multiplier right 1; counter++.
  - Exactly XLEN CALC edges.
- SIGN edge:
  - Negate the 64-bit accumulator if sa^sb.
  - result <= op==00 ? low half : high half.
  - done <= 1 for the following cycle only.
- Latency: accept edge E0; done high in the cycle after E(XLEN+1), i.e. 33 cycles after acceptance for XLEN=32. Fixed, independent of operand values; no early termination.
- Operand and start handling:
  - start while busy is ignored; no queuing.
  - start in the cycle done is high is accepted (state is IDLE).
  - a, b, op may change freely after the accept edge.
- Arithmetic boundary cases:
  - Magnitude of -2^(XLEN-1) is 2^(XLEN-1), representable unsigned; no overflow.
  - MUL low half is identical for signed/unsigned interpretation; op 00 uses sa=sb=0.
  - b=0 or a=0 yields 0 through the normal path; no special-casing.
- flush (synchronous):
  - In CALC or SIGN: next state IDLE, busy=0, no done, result keeps its previous value.
  - flush together with start in IDLE: no accept.
- Async reset mid-operation: immediate return to reset values; no done.
- busy is a registered decode of state; done is registered.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 33 cycles after the accept edge; busy high for 32+1 cycles.
- MULH a=b=0x80000000 -> result 0x40000000. MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFF.
- Back-to-back: start held high continuously with MULHU 0x10000*0x10000 then MUL 3*5 -> first done result 0x00000001, next accept in that done cycle, second done result 0x0000000F 33 cycles later; start pulses during busy ignored.
- flush asserted at CALC iteration 10 -> busy drops next cycle, no done pulse, result retains prior value; a new start is then accepted normally.
- rst_n pulsed low mid-CALC (asynchronously, between edges) -> busy/done/result read 0 immediately; after release, MUL 0*0x12345678 -> result 0.
- Randomized 1000 ops across all four op codes vs. a 64-bit reference model, including operands 0, 1, -1 and 0x80000000.
